// File: rtl/mv_pkg.sv
// Shared types for the motion-vector frame store: the MV pair layout and the fill-state encoding.
package mv_pkg;

    localparam int MV_W_DEFAULT = 4;

    typedef struct packed {
        logic signed [MV_W_DEFAULT-1:0] mvx;
        logic signed [MV_W_DEFAULT-1:0] mvy;
    } mv_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

endpackage

// File: rtl/mv_store_ram.sv
// Simple dual-port synchronous RAM holding both ping-pong banks; one write and one read port,
// registered read data that holds its value when no read is issued.
module mv_store_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/mv_frame_store.sv
// Ping-pong motion-vector store: one bank fills from the search engine while the other,
// holding the last completed frame, serves block-indexed reads.
module mv_frame_store
    import mv_pkg::*;
#(
    parameter int MV_W   = MV_W_DEFAULT,
    parameter int BLK_W  = 10,
    parameter int BLOCKS = 1020
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [MV_W-1:0]  mvx,
    input  logic [MV_W-1:0]  mvy,
    output logic             frame_done,
    output logic             overflow,
    output logic             err_short,
    output logic             rd_bank_valid,
    input  logic             rd_req,
    input  logic [BLK_W-1:0] rd_addr,
    output logic             rd_valid,
    output logic [MV_W-1:0]  rd_mvx,
    output logic [MV_W-1:0]  rd_mvy
);

    localparam logic [BLK_W-1:0] LAST_IDX = BLK_W'(BLOCKS - 1);

    state_t              state;
    logic                wr_bank;
    logic [BLK_W-1:0]    wr_cnt;
    logic                wr_en;
    logic                rd_zero;
    logic [2*MV_W-1:0]   rd_word;

    assign wr_ready = (state == FILL) && !frame_start;
    assign wr_en    = wr_valid && wr_ready;

    // frame_start always wins over a same-cycle write; a restart in FILL keeps the bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            err_short     <= 1'b0;
            rd_bank_valid <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state  <= FILL;
                        wr_cnt <= '0;
                    end
                end
                FILL: begin
                    if (frame_start) begin
                        err_short <= 1'b1;
                        wr_cnt    <= '0;
                        overflow  <= 1'b0;
                    end else if (wr_en) begin
                        wr_cnt <= wr_cnt + BLK_W'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state      <= FULL;
                            frame_done <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (frame_start) begin
                        state         <= FILL;
                        wr_bank       <= ~wr_bank;
                        wr_cnt        <= '0;
                        rd_bank_valid <= 1'b1;
                        overflow      <= 1'b0;
                    end else if (wr_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The zero mask is captured alongside the RAM read so both describe the same request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            rd_valid <= rd_req;
            if (rd_req)
                rd_zero <= !rd_bank_valid || (32'(rd_addr) >= BLOCKS);
        end
    end

    assign rd_mvx = rd_zero ? '0 : rd_word[2*MV_W-1:MV_W];
    assign rd_mvy = rd_zero ? '0 : rd_word[MV_W-1:0];

    mv_store_ram #(
        .DATA_W (2*MV_W),
        .ADDR_W (BLK_W+1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_cnt}),
        .wdata ({mvx, mvy}),
        .re    (rd_req),
        .raddr ({~wr_bank, rd_addr}),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_mv_frame_store.sv
// Bench for mv_frame_store with a frame-level reference model (fill queue plus committed frame).
module tb_mv_frame_store;

    localparam int MV_W   = 4;
    localparam int BLK_W  = 2;
    localparam int BLOCKS = 3;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             wr_valid;
    logic             wr_ready;
    logic [MV_W-1:0]  mvx;
    logic [MV_W-1:0]  mvy;
    logic             frame_done;
    logic             overflow;
    logic             err_short;
    logic             rd_bank_valid;
    logic             rd_req;
    logic [BLK_W-1:0] rd_addr;
    logic             rd_valid;
    logic [MV_W-1:0]  rd_mvx;
    logic [MV_W-1:0]  rd_mvy;

    int errors = 0;
    int checks = 0;

    // Reference model: frame open flag, pairs of the frame being filled, last completed frame
    bit         open;
    logic [7:0] fill_q[$];
    logic [7:0] committed [BLOCKS];
    bit         committed_valid;
    bit         exp_ovf;
    bit         exp_done;
    bit         exp_short;
    bit         exp_rd_valid;
    logic [7:0] exp_rd;

    mv_frame_store #(
        .MV_W   (MV_W),
        .BLK_W  (BLK_W),
        .BLOCKS (BLOCKS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .mvx           (mvx),
        .mvy           (mvy),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .err_short     (err_short),
        .rd_bank_valid (rd_bank_valid),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_mvx        (rd_mvx),
        .rd_mvy        (rd_mvy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        open            = 0;
        fill_q.delete();
        committed_valid = 0;
        exp_ovf         = 0;
        exp_done        = 0;
        exp_short       = 0;
        exp_rd_valid    = 0;
        exp_rd          = 8'h00;
    endtask

    function automatic bit exp_ready();
        return open && (fill_q.size() < BLOCKS) && !frame_start;
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT
    task automatic tick();
        logic [7:0] pair;
        pair = {mvx, mvy};
        exp_rd_valid = rd_req;
        if (rd_req)
            exp_rd = (!committed_valid || int'(rd_addr) >= BLOCKS) ? 8'h00 : committed[rd_addr];
        exp_done  = 0;
        exp_short = 0;
        if (frame_start) begin
            if (open && fill_q.size() == BLOCKS) begin
                for (int i = 0; i < BLOCKS; i++) committed[i] = fill_q[i];
                committed_valid = 1;
            end else if (open) begin
                exp_short = 1;
            end
            open = 1;
            fill_q.delete();
            exp_ovf = 0;
        end else if (open && wr_valid) begin
            if (fill_q.size() < BLOCKS) begin
                fill_q.push_back(pair);
                if (fill_q.size() == BLOCKS) exp_done = 1;
            end else begin
                exp_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({frame_done, overflow, err_short, rd_bank_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {frame_done, overflow, err_short, rd_bank_valid});
        end
        checks++;
        if ({rd_valid, rd_mvx, rd_mvy} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL reset_read: got %h expected 000", {rd_valid, rd_mvx, rd_mvy});
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", wr_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        frame_start = 1'b1;
        tick();
        for (int i = 1; i <= BLOCKS; i++) begin
            logic [MV_W-1:0] neg;
            neg      = MV_W'(0 - i);
            wr_valid = 1'b1;
            mvx      = MV_W'(i);
            mvy      = neg;
            #1;
            checks++;
            if (wr_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL fill_ready: got %b expected %b", wr_ready, exp_ready());
            end
            tick();
            checks++;
            if (frame_done !== exp_done) begin
                errors++;
                $display("[TB] FAIL fill_done[%0d]: got %b expected %b", i, frame_done, exp_done);
            end
        end
        tick();
        checks++;
        if ({frame_done, wr_ready} !== {exp_done, exp_ready()}) begin
            errors++;
            $display("[TB] FAIL full_state: got %b expected %b", {frame_done, wr_ready}, {exp_done, exp_ready()});
        end
    endtask

    task automatic test_read_while_write();
        frame_start = 1'b1;
        tick();
        checks++;
        if (rd_bank_valid !== committed_valid) begin
            errors++;
            $display("[TB] FAIL swap_bank_valid: got %b expected %b", rd_bank_valid, committed_valid);
        end
        for (int i = 0; i < BLOCKS; i++) begin
            rd_req   = 1'b1;
            rd_addr  = BLK_W'(i);
            wr_valid = 1'b1;
            mvx      = 4'd7;
            mvy      = 4'd7;
            tick();
            checks++;
            if ({rd_valid, rd_mvx, rd_mvy} !== {exp_rd_valid, exp_rd}) begin
                errors++;
                $display("[TB] FAIL rww_read[%0d]: got %h expected %h", i, {rd_valid, rd_mvx, rd_mvy}, {exp_rd_valid, exp_rd});
            end
        end
        tick();
        checks++;
        if ({rd_valid, rd_mvx, rd_mvy} !== {1'b0, exp_rd}) begin
            errors++;
            $display("[TB] FAIL rww_hold: got %h expected %h", {rd_valid, rd_mvx, rd_mvy}, {1'b0, exp_rd});
        end
    endtask

    task automatic test_overflow();
        wr_valid = 1'b1;
        mvx      = 4'd5;
        mvy      = 4'd5;
        tick();
        tick();
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got %b expected %b", overflow, exp_ovf);
        end
        frame_start = 1'b1;
        rd_req      = 1'b1;
        rd_addr     = 2'd0;
        tick();
        checks++;
        if ({overflow, rd_mvx, rd_mvy} !== {exp_ovf, exp_rd}) begin
            errors++;
            $display("[TB] FAIL ovf_clear_swap_read: got %h expected %h", {overflow, rd_mvx, rd_mvy}, {exp_ovf, exp_rd});
        end
        rd_req  = 1'b1;
        rd_addr = 2'd0;
        tick();
        checks++;
        if ({rd_mvx, rd_mvy} !== exp_rd) begin
            errors++;
            $display("[TB] FAIL ovf_mem_untouched: got %h expected %h", {rd_mvx, rd_mvy}, exp_rd);
        end
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            mvx      = MV_W'($urandom);
            mvy      = MV_W'($urandom);
            tick();
        end
        frame_start = 1'b1;
        tick();
        checks++;
        if ({err_short, rd_bank_valid} !== {exp_short, committed_valid}) begin
            errors++;
            $display("[TB] FAIL short_pulse: got %b expected %b", {err_short, rd_bank_valid}, {exp_short, committed_valid});
        end
        rd_req  = 1'b1;
        rd_addr = BLK_W'($urandom_range(0, BLOCKS - 1));
        tick();
        checks++;
        if ({err_short, rd_valid, rd_mvx, rd_mvy} !== {1'b0, exp_rd_valid, exp_rd}) begin
            errors++;
            $display("[TB] FAIL short_no_swap: got %h expected %h", {err_short, rd_valid, rd_mvx, rd_mvy}, {1'b0, exp_rd_valid, exp_rd});
        end
    endtask

    task automatic test_mid_reset();
        frame_start = 1'b1;
        tick();
        wr_valid = 1'b1;
        mvx      = 4'd3;
        mvy      = 4'd4;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({frame_done, overflow, err_short, rd_bank_valid, rd_valid, wr_ready, rd_mvx, rd_mvy} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", {frame_done, overflow, err_short, rd_bank_valid, rd_valid, wr_ready, rd_mvx, rd_mvy});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_req  = 1'b1;
            rd_addr = BLK_W'(a);
            tick();
            checks++;
            if ({rd_valid, rd_mvx, rd_mvy} !== {exp_rd_valid, exp_rd}) begin
                errors++;
                $display("[TB] FAIL noframe_read[%0d]: got %h expected %h", a, {rd_valid, rd_mvx, rd_mvy}, {exp_rd_valid, exp_rd});
            end
        end
        frame_start = 1'b1;
        tick();
        for (int i = 0; i < BLOCKS; i++) begin
            wr_valid = 1'b1;
            mvx      = MV_W'($urandom);
            mvy      = MV_W'($urandom);
            tick();
        end
        checks++;
        if (rd_bank_valid !== committed_valid) begin
            errors++;
            $display("[TB] FAIL post_reset_bank_valid: got %b expected %b", rd_bank_valid, committed_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            frame_start = ($urandom_range(0, 9) == 0) || (fill_q.size() == BLOCKS && $urandom_range(0, 2) == 0);
            wr_valid    = ($urandom_range(0, 3) != 0);
            mvx         = MV_W'($urandom);
            mvy         = MV_W'($urandom);
            rd_req      = $urandom_range(0, 1) == 1;
            rd_addr     = BLK_W'($urandom);
            #1;
            checks++;
            if (wr_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", n, wr_ready, exp_ready());
            end
            tick();
            checks++;
            if ({frame_done, err_short, overflow, rd_bank_valid} !== {exp_done, exp_short, exp_ovf, committed_valid}) begin
                errors++;
                $display("[TB] FAIL rnd_flags[%0d]: got %b expected %b", n, {frame_done, err_short, overflow, rd_bank_valid}, {exp_done, exp_short, exp_ovf, committed_valid});
            end
            checks++;
            if ({rd_valid, rd_mvx, rd_mvy} !== {exp_rd_valid, exp_rd}) begin
                errors++;
                $display("[TB] FAIL rnd_read[%0d]: got %h expected %h", n, {rd_valid, rd_mvx, rd_mvy}, {exp_rd_valid, exp_rd});
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        mvx         = '0;
        mvy         = '0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        test_reset();
        test_fill();
        test_read_while_write();
        test_overflow();
        test_short_frame();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
